mix_sequencer: RTL and testbench

MIX_SEQUENCER -- requirements
Module: mix_sequencer

---
 rtl/mix_pkg.sv | 16 +
 rtl/mix_sequencer.sv | 114 +++++++++++
 tb/tb_mix_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mix_pkg.sv
// Shared definitions for the mixer sequencer: default widths, level ceiling and FSM encoding.
package mix_pkg;
  localparam int DEF_SAMPLE_W = 8;
  localparam int DEF_MIX_W    = 12;
  localparam int DEF_LEVEL_W  = 3;
  localparam int MAX_LEVEL    = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD1   = 3'd1,
    ST_LOAD2   = 3'd2,
    ST_EXEC    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_OUT     = 3'd5
  } state_t;
endpackage

// File: rtl/mix_sequencer.sv
// Per-tick sequencer: loads two oscillator channels into a shared mixer, runs it, and hands
// the result to a DAC with ready/valid backpressure. Ticks arriving while busy are counted as drops.
module mix_sequencer
  import mix_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int MIX_W    = DEF_MIX_W,
  parameter int LEVEL_W  = DEF_LEVEL_W
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_tick,
  input  logic [SAMPLE_W-1:0] i_osc1_sample,
  input  logic [SAMPLE_W-1:0] i_osc2_sample,
  input  logic [LEVEL_W-1:0]  i_osc1_level,
  input  logic [LEVEL_W-1:0]  i_osc2_level,
  input  logic [1:0]          i_mute,
  output logic [SAMPLE_W-1:0] o_sample,
  output logic                o_sample_1_load,
  output logic                o_sample_2_load,
  output logic [LEVEL_W-1:0]  o_sample_1_level,
  output logic [LEVEL_W-1:0]  o_sample_2_level,
  output logic                o_execute,
  input  logic [MIX_W-1:0]    i_mix,
  output logic [MIX_W-1:0]    o_dac_data,
  output logic                o_dac_valid,
  input  logic                i_dac_ready,
  output logic                o_busy,
  output logic                o_overrun,
  output logic [7:0]          o_drop_count,
  input  logic                i_clear_overrun
);

  function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] lvl);
    return (lvl > LEVEL_W'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL) : lvl;
  endfunction

  state_t                r_state;
  logic [SAMPLE_W-1:0]   r_s2;
  logic [LEVEL_W-1:0]    r_l2;
  logic                  r_mute2;
  logic                  w_drop;

  assign w_drop = i_tick && (r_state != ST_IDLE);
  assign o_busy = (r_state != ST_IDLE);

  // Outputs are computed from the state being entered, so each load cycle sees stable registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state          <= ST_IDLE;
      r_s2             <= '0;
      r_l2             <= '0;
      r_mute2          <= 1'b0;
      o_sample         <= '0;
      o_sample_1_load  <= 1'b0;
      o_sample_2_load  <= 1'b0;
      o_sample_1_level <= '0;
      o_sample_2_level <= '0;
      o_execute        <= 1'b0;
      o_dac_data       <= '0;
      o_dac_valid      <= 1'b0;
      o_overrun        <= 1'b0;
      o_drop_count     <= '0;
    end else begin
      o_sample        <= '0;
      o_sample_1_load <= 1'b0;
      o_sample_2_load <= 1'b0;
      o_execute       <= 1'b0;
      case (r_state)
        ST_IDLE: if (i_tick) begin
          // Channel 1 goes straight to the bus; channel 2 waits in the snapshot for one cycle.
          r_s2             <= i_osc2_sample;
          r_l2             <= clamp_level(i_osc2_level);
          r_mute2          <= i_mute[1];
          o_sample         <= i_mute[0] ? '0 : i_osc1_sample;
          o_sample_1_level <= clamp_level(i_osc1_level);
          o_sample_1_load  <= 1'b1;
          r_state          <= ST_LOAD1;
        end
        ST_LOAD1: begin
          o_sample         <= r_mute2 ? '0 : r_s2;
          o_sample_2_level <= r_l2;
          o_sample_2_load  <= 1'b1;
          r_state          <= ST_LOAD2;
        end
        ST_LOAD2: begin
          o_execute <= 1'b1;
          r_state   <= ST_EXEC;
        end
        ST_EXEC: r_state <= ST_CAPTURE;
        ST_CAPTURE: begin
          o_dac_data  <= i_mix;
          o_dac_valid <= 1'b1;
          r_state     <= ST_OUT;
        end
        ST_OUT: if (i_dac_ready) begin
          o_dac_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // A drop in the clearing cycle survives the clear as a count of one.
      if (i_clear_overrun) begin
        o_overrun    <= w_drop;
        o_drop_count <= w_drop ? 8'd1 : 8'd0;
      end else if (w_drop) begin
        o_overrun <= 1'b1;
        if (o_drop_count != 8'hFF) o_drop_count <= o_drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mix_sequencer.sv
// Directed bench: table of single-tick sequences plus hand-written backpressure, overrun and reset cases.
module tb_mix_sequencer;
  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_tick;
  logic [7:0]  i_osc1_sample, i_osc2_sample;
  logic [2:0]  i_osc1_level, i_osc2_level;
  logic [1:0]  i_mute;
  logic [7:0]  o_sample;
  logic        o_sample_1_load, o_sample_2_load;
  logic [2:0]  o_sample_1_level, o_sample_2_level;
  logic        o_execute;
  logic [11:0] i_mix;
  logic [11:0] o_dac_data;
  logic        o_dac_valid;
  logic        i_dac_ready;
  logic        o_busy, o_overrun;
  logic [7:0]  o_drop_count;
  logic        i_clear_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  mix_sequencer dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_tick(i_tick),
    .i_osc1_sample(i_osc1_sample), .i_osc2_sample(i_osc2_sample),
    .i_osc1_level(i_osc1_level), .i_osc2_level(i_osc2_level), .i_mute(i_mute),
    .o_sample(o_sample), .o_sample_1_load(o_sample_1_load), .o_sample_2_load(o_sample_2_load),
    .o_sample_1_level(o_sample_1_level), .o_sample_2_level(o_sample_2_level),
    .o_execute(o_execute), .i_mix(i_mix), .o_dac_data(o_dac_data), .o_dac_valid(o_dac_valid),
    .i_dac_ready(i_dac_ready), .o_busy(o_busy), .o_overrun(o_overrun),
    .o_drop_count(o_drop_count), .i_clear_overrun(i_clear_overrun)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [7:0]  s1, s2;
    logic [2:0]  l1, l2;
    logic [1:0]  mute;
    logic [11:0] mix;
    logic [7:0]  e_smp1, e_smp2;
    logic [2:0]  e_l1, e_l2;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and sample 1ns after the edge; strobes must never overlap.
  task automatic step();
    @(posedge i_clock);
    #1;
    chk("strobe_onehot0", 32'($onehot0({o_sample_1_load, o_sample_2_load, o_execute, o_dac_valid})), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sample"}, o_sample, 0);
    chk({tag, "_strobes"}, {o_sample_1_load, o_sample_2_load, o_execute, o_dac_valid}, 0);
    chk({tag, "_levels"}, {o_sample_1_level, o_sample_2_level}, 0);
    chk({tag, "_dac_data"}, o_dac_data, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_overrun"}, {o_overrun, o_drop_count}, 0);
  endtask

  task automatic start_tick(input vec_t v);
    i_osc1_sample = v.s1; i_osc2_sample = v.s2;
    i_osc1_level = v.l1; i_osc2_level = v.l2;
    i_mute = v.mute; i_mix = v.mix; i_tick = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    i_dac_ready = 1'b1;
    start_tick(v);
    step();
    i_tick = 1'b0;
    // Disturb live inputs so the snapshot is what gets checked.
    i_osc2_sample = ~v.s2; i_osc2_level = 3'd7; i_mute = ~v.mute;
    chk("ld1_strobe", o_sample_1_load, 1);
    chk("ld1_sample", o_sample, v.e_smp1);
    chk("ld1_level", o_sample_1_level, v.e_l1);
    chk("ld1_busy", o_busy, 1);
    step();
    chk("ld2_strobe", o_sample_2_load, 1);
    chk("ld2_sample", o_sample, v.e_smp2);
    chk("ld2_level", o_sample_2_level, v.e_l2);
    chk("ld2_level1_held", o_sample_1_level, v.e_l1);
    step();
    chk("exec_strobe", o_execute, 1);
    step();
    chk("capture_quiet", {o_execute, o_dac_valid}, 0);
    step();
    i_mix = ~v.mix;
    chk("out_valid", o_dac_valid, 1);
    chk("out_data", o_dac_data, v.mix);
    step();
    chk("back_idle_valid", o_dac_valid, 0);
    chk("back_idle_busy", o_busy, 0);
  endtask

  vec_t bp;
  vec_t ov;

  initial begin
    vecs[0] = '{s1:8'h80, s2:8'h40, l1:3'd1, l2:3'd1, mute:2'b00, mix:12'h0C0,
                e_smp1:8'h80, e_smp2:8'h40, e_l1:3'd1, e_l2:3'd1};
    vecs[1] = '{s1:8'hAA, s2:8'h55, l1:3'd7, l2:3'd3, mute:2'b10, mix:12'h123,
                e_smp1:8'hAA, e_smp2:8'h00, e_l1:3'd5, e_l2:3'd3};
    vecs[2] = '{s1:8'hFF, s2:8'h01, l1:3'd5, l2:3'd6, mute:2'b01, mix:12'hFFF,
                e_smp1:8'h00, e_smp2:8'h01, e_l1:3'd5, e_l2:3'd5};
    vecs[3] = '{s1:8'h12, s2:8'h34, l1:3'd0, l2:3'd0, mute:2'b11, mix:12'h000,
                e_smp1:8'h00, e_smp2:8'h00, e_l1:3'd0, e_l2:3'd0};
    bp = '{s1:8'h21, s2:8'h43, l1:3'd2, l2:3'd4, mute:2'b00, mix:12'hA5C,
           e_smp1:8'h21, e_smp2:8'h43, e_l1:3'd2, e_l2:3'd4};
    ov = '{s1:8'h01, s2:8'h02, l1:3'd3, l2:3'd3, mute:2'b00, mix:12'h555,
           e_smp1:8'h01, e_smp2:8'h02, e_l1:3'd3, e_l2:3'd3};

    i_reset = 1'b1; i_tick = 1'b0; i_osc1_sample = '0; i_osc2_sample = '0;
    i_osc1_level = '0; i_osc2_level = '0; i_mute = '0; i_mix = '0;
    i_dac_ready = 1'b0; i_clear_overrun = 1'b0;
    step(); step();
    chk_all_zero("reset");
    i_reset = 1'b0;
    step();

    foreach (vecs[i]) run_vec(vecs[i]);
    chk("no_drops_yet", {o_overrun, o_drop_count}, 0);

    // Backpressure: hold ready low through OUT, then a tick in the accepting cycle is dropped.
    i_dac_ready = 1'b0;
    start_tick(bp);
    step(); i_tick = 1'b0;
    repeat (4) step();
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", o_dac_valid, 1);
      chk("bp_data", o_dac_data, bp.mix);
      i_mix = 12'(c);
      step();
    end
    chk("bp_still_valid", o_dac_valid, 1);
    i_dac_ready = 1'b1; i_tick = 1'b1;
    step();
    i_tick = 1'b0;
    chk("bp_done_valid", o_dac_valid, 0);
    chk("bp_done_busy", o_busy, 0);
    chk("bp_drop", {o_overrun, o_drop_count}, {1'b1, 8'd1});
    i_clear_overrun = 1'b1;
    step();
    i_clear_overrun = 1'b0;
    chk("clear", {o_overrun, o_drop_count}, 0);

    // Overrun: tick held over the accepting edge and three busy edges.
    i_dac_ready = 1'b0;
    start_tick(ov);
    repeat (4) step();
    i_tick = 1'b0;
    chk("ovr_three", {o_overrun, o_drop_count}, {1'b1, 8'd3});
    step();
    chk("ovr_in_out", o_dac_valid, 1);
    i_tick = 1'b1;
    repeat (300) step();
    chk("ovr_saturate", {o_overrun, o_drop_count}, {1'b1, 8'd255});
    i_clear_overrun = 1'b1;
    step();
    chk("clear_with_drop", {o_overrun, o_drop_count}, {1'b1, 8'd1});
    i_tick = 1'b0;
    step();
    chk("clear_alone", {o_overrun, o_drop_count}, 0);
    i_clear_overrun = 1'b0;
    i_dac_ready = 1'b1;
    step();
    chk("ovr_done_busy", o_busy, 0);
    chk("ovr_data_kept", o_dac_data, ov.mix);

    // Reset in EXEC wins over concurrent tick, ready and clear.
    start_tick(vecs[0]);
    step(); i_tick = 1'b0;
    step(); step();
    chk("pre_reset_exec", o_execute, 1);
    i_reset = 1'b1; i_tick = 1'b1; i_clear_overrun = 1'b1;
    step();
    chk_all_zero("rst_exec");
    i_reset = 1'b0; i_tick = 1'b0; i_clear_overrun = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("post_reset_quiet", {o_sample_1_load, o_sample_2_load, o_execute, o_dac_valid, o_busy}, 0);
    end
    run_vec(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
